dds_sweep_ctrl: RTL and testbench

// Sweep scheduler for the DDS signal generator: a host-side register write port
// (UART command decoder) loads sweep settings; on Start the block drives the DDS

---
 rtl/dds_sweep_ctrl_if.sv | 28 ++
 rtl/dds_sweep_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Host/DDS-side signal bundle for the DDS frequency sweep scheduler.
// The master is the command decoder side; the slave is the scheduler.
interface dds_sweep_ctrl_if #(
    parameter int FW_W = 32,
    parameter int PW_W = 12
);
    logic            Wr_en;
    logic [2:0]      Wr_addr;
    logic [FW_W-1:0] Wr_data;
    logic            Start;
    logic            Abort;
    logic            DDS_EN;
    logic [FW_W-1:0] Fword;
    logic [PW_W-1:0] Pword;
    logic            Busy;
    logic            Done;
    logic [15:0]     Sweep_cnt;

    modport master (
        output Wr_en, Wr_addr, Wr_data, Start, Abort,
        input  DDS_EN, Fword, Pword, Busy, Done, Sweep_cnt
    );

    modport slave (
        input  Wr_en, Wr_addr, Wr_data, Start, Abort,
        output DDS_EN, Fword, Pword, Busy, Done, Sweep_cnt
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep scheduler: steps the frequency word from START_F to STOP_F
// with a fixed dwell per point, single-shot or continuous.
module dds_sweep_ctrl #(
    parameter int FW_W    = 32,
    parameter int PW_W    = 12,
    parameter int DWELL_W = 24
) (
    input  logic             Clk,
    input  logic             Rst_n,
    dds_sweep_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    // host-visible configuration
    logic [FW_W-1:0]    start_f, stop_f, step_f;
    logic [DWELL_W-1:0] dwell;
    logic [PW_W-1:0]    pword;
    logic [1:0]         ctrl;

    // working copies frozen at Start
    logic [FW_W-1:0]    w_start, w_stop, w_step;
    logic [DWELL_W-1:0] w_dwell;
    logic               w_cont, w_hold, w_up;

    state_t             state, state_d;
    logic [FW_W-1:0]    fword, fword_d, f_next;
    logic [DWELL_W-1:0] cnt, cnt_d, dwell_eff;
    logic               en, en_d, busy, busy_d, done, done_d;
    logic [15:0]        scnt, scnt_d;
    logic               load;
    logic [FW_W:0]      up_sum;
    logic [FW_W-1:0]    dn_diff;

    assign dwell_eff = (dwell == '0) ? ONE : dwell;

    // configuration register file, writable in any state
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            start_f <= '0;
            stop_f  <= '0;
            step_f  <= '0;
            dwell   <= ONE;
            pword   <= '0;
            ctrl    <= '0;
        end else if (bus.Wr_en) begin
            case (bus.Wr_addr)
                3'd0:    start_f <= bus.Wr_data;
                3'd1:    stop_f  <= bus.Wr_data;
                3'd2:    step_f  <= bus.Wr_data;
                3'd3:    dwell   <= bus.Wr_data[DWELL_W-1:0];
                3'd4:    pword   <= bus.Wr_data[PW_W-1:0];
                3'd5:    ctrl    <= bus.Wr_data[1:0];
                default: ;
            endcase
        end
    end

    // snapshot of sweep settings when a Start is accepted
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            w_start <= '0;
            w_stop  <= '0;
            w_step  <= '0;
            w_dwell <= ONE;
            w_cont  <= 1'b0;
            w_hold  <= 1'b0;
            w_up    <= 1'b1;
        end else if (load) begin
            w_start <= start_f;
            w_stop  <= stop_f;
            w_step  <= step_f;
            w_dwell <= dwell_eff;
            w_cont  <= ctrl[0];
            w_hold  <= ctrl[1];
            w_up    <= (stop_f >= start_f);
        end
    end

    // next sweep point, clamped to STOP_F on overshoot or wrap
    always_comb begin
        up_sum  = {1'b0, fword} + {1'b0, w_step};
        dn_diff = fword - w_step;
        f_next  = w_stop;
        if (w_step != '0) begin
            if (w_up) begin
                if (!up_sum[FW_W] && up_sum[FW_W-1:0] <= w_stop)
                    f_next = up_sum[FW_W-1:0];
            end else begin
                if (w_step <= fword && dn_diff >= w_stop)
                    f_next = dn_diff;
            end
        end
    end

    // state and output register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            fword <= '0;
            cnt   <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            scnt  <= '0;
        end else begin
            state <= state_d;
            fword <= fword_d;
            cnt   <= cnt_d;
            en    <= en_d;
            busy  <= busy_d;
            done  <= done_d;
            scnt  <= scnt_d;
        end
    end

    // sweep sequencing; Abort overrides everything, Start is dropped in RUN
    always_comb begin
        state_d = state;
        fword_d = fword;
        cnt_d   = cnt;
        en_d    = en;
        busy_d  = busy;
        done_d  = 1'b0;
        scnt_d  = scnt;
        load    = 1'b0;
        if (bus.Abort) begin
            state_d = IDLE;
            fword_d = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (bus.Start) begin
                        state_d = RUN;
                        fword_d = start_f;
                        cnt_d   = dwell_eff - ONE;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        load    = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - ONE;
                    end else if (fword != w_stop) begin
                        fword_d = f_next;
                        cnt_d   = w_dwell - ONE;
                    end else begin
                        scnt_d = scnt + 16'd1;
                        if (w_cont) begin
                            fword_d = w_start;
                            cnt_d   = w_dwell - ONE;
                        end else begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                            if (w_hold) begin
                                state_d = HOLD;
                            end else begin
                                state_d = IDLE;
                                fword_d = '0;
                                en_d    = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    fword_d = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.DDS_EN    = en;
    assign bus.Fword     = fword;
    assign bus.Pword     = pword;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.Sweep_cnt = scnt;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweeps with a per-cycle expected
// trace queue, checked by a monitor whenever the DUT drives the DDS.
module tb_dds_sweep_ctrl;
    typedef struct {
        int          id;
        logic        en;
        logic [31:0] f;
        logic        busy;
        logic        done;
        logic [15:0] sc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   tid = 0;
    exp_t q[$];
    exp_t e;

    dds_sweep_ctrl_if #(.FW_W(32), .PW_W(12)) bus ();

    dds_sweep_ctrl #(.FW_W(32), .PW_W(12), .DWELL_W(24)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // monitor: every cycle the DUT is active must match the next expectation
    always @(negedge Clk) begin
        if (Rst_n && (bus.Busy || bus.Done || bus.DDS_EN)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output en=%0b f=%0h busy=%0b done=%0b sc=%0d",
                         bus.DDS_EN, bus.Fword, bus.Busy, bus.Done, bus.Sweep_cnt);
            end else begin
                e = q.pop_front();
                if (bus.DDS_EN !== e.en || bus.Fword !== e.f || bus.Busy !== e.busy ||
                    bus.Done !== e.done || bus.Sweep_cnt !== e.sc) begin
                    errors++;
                    $display("FAIL trace_t%0d got en=%0b f=%0h busy=%0b done=%0b sc=%0d exp en=%0b f=%0h busy=%0b done=%0b sc=%0d",
                             e.id, bus.DDS_EN, bus.Fword, bus.Busy, bus.Done, bus.Sweep_cnt,
                             e.en, e.f, e.busy, e.done, e.sc);
                end
            end
        end
    end

    task automatic push(input int n, input logic en, input logic [31:0] f,
                        input logic busy, input logic done, input logic [15:0] sc);
        exp_t x;
        x.id = tid; x.en = en; x.f = f; x.busy = busy; x.done = done; x.sc = sc;
        for (int i = 0; i < n; i++) q.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.Wr_en = 1'b1; bus.Wr_addr = a; bus.Wr_data = d;
        cyc(1);
        bus.Wr_en = 1'b0;
    endtask

    task automatic start_pulse();
        bus.Start = 1'b1;
        cyc(1);
        bus.Start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    // wait (bounded) for the trace to be consumed, then a quiet margin
    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) cyc(1);
        cyc(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending exp 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic setup(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                         input logic [31:0] dw, input logic [31:0] c);
        wr(3'd0, s); wr(3'd1, p); wr(3'd2, st); wr(3'd3, dw); wr(3'd5, c);
    endtask

    initial begin
        bus.Wr_en = 1'b0; bus.Wr_addr = '0; bus.Wr_data = '0;
        bus.Start = 1'b0; bus.Abort = 1'b0;
        #12;
        chk("reset_outputs", {1'b0, bus.DDS_EN, bus.Fword, bus.Pword, bus.Busy,
            bus.Done, bus.Sweep_cnt}, 64'd0);
        Rst_n = 1'b1;
        cyc(1);

        // 1: up sweep, single shot
        tid = 1;
        setup(100, 400, 100, 4, 0);
        push(4, 1, 100, 1, 0, 0); push(4, 1, 200, 1, 0, 0);
        push(4, 1, 300, 1, 0, 0); push(4, 1, 400, 1, 0, 0);
        push(1, 0, 0, 0, 1, 1);
        start_pulse();
        drain("t1");
        chk("t1_en_off", {63'd0, bus.DDS_EN}, 64'd0);
        chk("t1_sweep_cnt", {48'd0, bus.Sweep_cnt}, 64'd1);

        // phase word register, LSBs of the write data
        wr(3'd4, 32'h1234_5ABC);
        chk("pword", {52'd0, bus.Pword}, 64'hABC);

        // 2: down sweep with clamp at STOP
        tid = 2;
        setup(1000, 250, 300, 2, 0);
        push(2, 1, 1000, 1, 0, 1); push(2, 1, 700, 1, 0, 1);
        push(2, 1, 400, 1, 0, 1); push(2, 1, 250, 1, 0, 1);
        push(1, 0, 0, 0, 1, 2);
        start_pulse();
        drain("t2");

        // 3: 32-bit overflow clamps to STOP
        tid = 3;
        setup(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 2, 0);
        push(2, 1, 32'hFFFF_FF00, 1, 0, 2); push(2, 1, 32'hFFFF_FFFF, 1, 0, 2);
        push(1, 0, 0, 0, 1, 3);
        start_pulse();
        drain("t3");

        // 4: continuous, aborted mid third pass
        tid = 4;
        setup(10, 30, 10, 3, 1);
        push(3, 1, 10, 1, 0, 3); push(3, 1, 20, 1, 0, 3); push(3, 1, 30, 1, 0, 3);
        push(3, 1, 10, 1, 0, 4); push(3, 1, 20, 1, 0, 4); push(3, 1, 30, 1, 0, 4);
        push(3, 1, 10, 1, 0, 5); push(1, 1, 20, 1, 0, 5);
        start_pulse();
        cyc(21);
        bus.Abort = 1'b1;
        cyc(1);
        bus.Abort = 1'b0;
        chk("t4_abort_idle", {61'd0, bus.DDS_EN, bus.Busy, bus.Done}, 64'd0);
        drain("t4");
        chk("t4_sweep_cnt", {48'd0, bus.Sweep_cnt}, 64'd5);

        // 5a: hold at STOP, then Start+Abort together returns to idle
        tid = 5;
        setup(5, 7, 1, 1, 2);
        push(1, 1, 5, 1, 0, 5); push(1, 1, 6, 1, 0, 5); push(1, 1, 7, 1, 0, 5);
        push(1, 1, 7, 0, 1, 6); push(2, 1, 7, 0, 0, 6);
        start_pulse();
        cyc(5);
        bus.Start = 1'b1; bus.Abort = 1'b1;
        cyc(1);
        bus.Start = 1'b0; bus.Abort = 1'b0;
        chk("t5_start_abort", {29'd0, bus.DDS_EN, bus.Fword, bus.Busy, bus.Done}, 64'd0);
        drain("t5a");

        // 5b: STOP_F write and Start while busy leave the sweep untouched
        tid = 6;
        setup(0, 40, 10, 2, 0);
        push(2, 1, 0, 1, 0, 6); push(2, 1, 10, 1, 0, 6); push(2, 1, 20, 1, 0, 6);
        push(2, 1, 30, 1, 0, 6); push(2, 1, 40, 1, 0, 6);
        push(1, 0, 0, 0, 1, 7);
        start_pulse();
        cyc(2);
        wr(3'd1, 20);
        start_pulse();
        drain("t5b");

        // START==STOP with DWELL=0: single one-cycle point
        tid = 7;
        wr(3'd0, 55); wr(3'd1, 55); wr(3'd3, 0);
        push(1, 1, 55, 1, 0, 7); push(1, 0, 0, 0, 1, 8);
        start_pulse();
        drain("t_equal");

        // 6: reset mid-sweep, then defaults give a one-cycle point at 0
        tid = 8;
        setup(100, 400, 100, 4, 0);
        push(2, 1, 100, 1, 0, 8);
        start_pulse();
        cyc(2);
        Rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {1'b0, bus.DDS_EN, bus.Fword, bus.Pword, bus.Busy,
            bus.Done, bus.Sweep_cnt}, 64'd0);
        #3;
        Rst_n = 1'b1;
        cyc(1);
        drain("t6_pre");
        tid = 9;
        push(1, 1, 0, 1, 0, 0); push(1, 0, 0, 0, 1, 1);
        start_pulse();
        drain("t6_defaults");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
